// File: rtl/pin_entry_tx.sv
// pin_entry_tx: collects a two-nibble PIN from a keypad, sends it to a gate controller and waits for its answer.
// Latency: pin_valid one cycle after key_enter in READY; accepted/rejected/timeout one cycle after the deciding cycle.
// Backpressure: none; keys arriving while a PIN is outstanding (or during lockout) are dropped.
// Optional feature macro: PIN_ENTRY_LOCKOUT_EN (lock the keypad after three consecutive rejects).
module pin_entry_tx #(
   parameter int RESP_TIMEOUT = 16,
   parameter int LOCK_CYCLES  = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       key_enter,
   input  logic       key_clear,
   input  logic       gate_open,
   input  logic       alarm_wrong_pin,
   output logic [7:0] input_password,
   output logic       pin_valid,
   output logic       busy,
   output logic [1:0] digit_count,
   output logic       accepted,
   output logic       rejected,
   output logic       timeout,
   output logic       locked
);

   // The response timer and lock timer need these minimums to express their terminal counts.
   if (RESP_TIMEOUT < 2 || LOCK_CYCLES < 1) begin : g_bad_cfg
      $error("pin_entry_tx: RESP_TIMEOUT must be >= 2 and LOCK_CYCLES >= 1");
   end

   localparam int TW = $clog2(RESP_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(RESP_TIMEOUT - 1);
   localparam logic [TW-1:0] TMO_SAT  = TW'(RESP_TIMEOUT);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] DIGIT1    = 3'd1;
   localparam logic [2:0] READY     = 3'd2;
   localparam logic [2:0] SEND      = 3'd3;
   localparam logic [2:0] WAIT_RESP = 3'd4;
`ifdef PIN_ENTRY_LOCKOUT_EN
   localparam logic [2:0] LOCKED    = 3'd5;
   localparam int LW = $clog2(LOCK_CYCLES + 1);
   localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
`endif

   logic [2:0]    state_q, state_d;
   logic [7:0]    pin_q, pin_d;
   logic [1:0]    cnt_d;
   logic [TW-1:0] timer_q, timer_d;
`ifdef PIN_ENTRY_LOCKOUT_EN
   logic [1:0]    rej_q, rej_d;
   logic [LW-1:0] lock_q, lock_d;
   logic          locked_d;
`endif

   logic [7:0] password_d;
   logic       pin_valid_d, busy_d, accepted_d, rejected_d, timeout_d;

   // State register, PIN datapath and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         pin_q          <= 8'h00;
         digit_count    <= 2'd0;
         timer_q        <= '0;
         input_password <= 8'h00;
         pin_valid      <= 1'b0;
         busy           <= 1'b0;
         accepted       <= 1'b0;
         rejected       <= 1'b0;
         timeout        <= 1'b0;
`ifdef PIN_ENTRY_LOCKOUT_EN
         rej_q          <= 2'd0;
         lock_q         <= '0;
         locked         <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         pin_q          <= pin_d;
         digit_count    <= cnt_d;
         timer_q        <= timer_d;
         input_password <= password_d;
         pin_valid      <= pin_valid_d;
         busy           <= busy_d;
         accepted       <= accepted_d;
         rejected       <= rejected_d;
         timeout        <= timeout_d;
`ifdef PIN_ENTRY_LOCKOUT_EN
         rej_q          <= rej_d;
         lock_q         <= lock_d;
         locked         <= locked_d;
`endif
      end
   end

`ifndef PIN_ENTRY_LOCKOUT_EN
   assign locked = 1'b0;
`endif

   // Next state plus the PIN, digit count and timers that move with each transition.
   always_comb begin
      state_d = state_q;
      pin_d   = pin_q;
      cnt_d   = digit_count;
      timer_d = timer_q;
`ifdef PIN_ENTRY_LOCKOUT_EN
      rej_d   = rej_q;
      lock_d  = lock_q;
`endif
      case (state_q)
         IDLE: begin
            if (key_clear) begin
               pin_d = 8'h00;
               cnt_d = 2'd0;
            end else if (key_valid) begin
               pin_d[7:4] = key_code;
               cnt_d      = 2'd1;
               state_d    = DIGIT1;
            end
         end
         DIGIT1: begin
            if (key_clear) begin
               pin_d   = 8'h00;
               cnt_d   = 2'd0;
               state_d = IDLE;
            end else if (key_valid) begin
               pin_d[3:0] = key_code;
               cnt_d      = 2'd2;
               state_d    = READY;
            end
         end
         READY: begin
            // A third digit is dropped so the held PIN cannot be overwritten.
            if (key_clear) begin
               pin_d   = 8'h00;
               cnt_d   = 2'd0;
               state_d = IDLE;
            end else if (key_enter) begin
               timer_d = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            timer_d = '0;
            state_d = WAIT_RESP;
         end
         WAIT_RESP: begin
            // Accept beats reject, and any answer beats the timeout.
            if (gate_open) begin
               pin_d   = 8'h00;
               cnt_d   = 2'd0;
               state_d = IDLE;
`ifdef PIN_ENTRY_LOCKOUT_EN
               rej_d   = 2'd0;
`endif
            end else if (alarm_wrong_pin) begin
               pin_d   = 8'h00;
               cnt_d   = 2'd0;
               state_d = IDLE;
`ifdef PIN_ENTRY_LOCKOUT_EN
               rej_d   = rej_q + 2'd1;
               if (rej_q == 2'd2) begin
                  lock_d  = '0;
                  state_d = LOCKED;
               end
`endif
            end else if (timer_q == TMO_LAST) begin
               pin_d   = 8'h00;
               cnt_d   = 2'd0;
               state_d = IDLE;
            end else if (timer_q != TMO_SAT) begin
               timer_d = timer_q + TW'(1);
            end
         end
`ifdef PIN_ENTRY_LOCKOUT_EN
         LOCKED: begin
            if (lock_q == LOCK_LAST) begin
               lock_d  = '0;
               rej_d   = 2'd0;
               state_d = IDLE;
            end else begin
               lock_d = lock_q + LW'(1);
            end
         end
`endif
         default: begin
            pin_d   = 8'h00;
            cnt_d   = 2'd0;
            state_d = IDLE;
         end
      endcase
   end

   // Output values for the next cycle, derived from the transition being taken.
   always_comb begin
      pin_valid_d = (state_d == SEND);
      busy_d      = (state_d == SEND) || (state_d == WAIT_RESP);
      password_d  = busy_d ? pin_d : 8'h00;
      accepted_d  = (state_q == WAIT_RESP) && gate_open;
      rejected_d  = (state_q == WAIT_RESP) && !gate_open && alarm_wrong_pin;
      timeout_d   = (state_q == WAIT_RESP) && !gate_open && !alarm_wrong_pin &&
                    (timer_q == TMO_LAST);
`ifdef PIN_ENTRY_LOCKOUT_EN
      locked_d    = (state_d == LOCKED);
`endif
   end

endmodule

// File: doc/pin_entry_tx.md
PIN_ENTRY_TX -- requirements
Module: pin_entry_tx

Interface
REQ-001 The module SHALL have parameter RESP_TIMEOUT, default 16, which is the number of WAIT_RESP cycles allowed before a timeout is declared.
REQ-002 The module SHALL have parameter LOCK_CYCLES, default 64, which is the lockout duration in cycles (used only with LOCKOUT_EN).
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock; all flops are rising-edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port key_valid, input, 1 bit: one-cycle strobe qualifying key_code.
REQ-006 The module SHALL have port key_code, input, 4 bits: nibble value of the pressed key.
REQ-007 The module SHALL have port key_enter, input, 1 bit: one-cycle strobe that requests transmission of the PIN.
REQ-008 The module SHALL have port key_clear, input, 1 bit: one-cycle strobe that discards the PIN entered so far.
REQ-009 The module SHALL have port gate_open, input, 1 bit: controller response meaning the PIN was accepted.
REQ-010 The module SHALL have port alarm_wrong_pin, input, 1 bit: controller response meaning the PIN was rejected.
REQ-011 The module SHALL have port input_password, output, 8 bits: the PIN driven to the controller.
REQ-012 The module SHALL have port pin_valid, output, 1 bit: one-cycle strobe qualifying input_password.
REQ-013 The module SHALL have port busy, output, 1 bit: high while a transmission is outstanding.
REQ-014 The module SHALL have port digit_count, output, 2 bits: number of nibbles currently held (0 to 2).
REQ-015 The module SHALL have port accepted, output, 1 bit: one-cycle pulse on an accept response.
REQ-016 The module SHALL have port rejected, output, 1 bit: one-cycle pulse on a reject response.
REQ-017 The module SHALL have port timeout, output, 1 bit: one-cycle pulse when no response arrives in time.
REQ-018 The module SHALL have port locked, output, 1 bit: high while lockout is active.

Function
REQ-019 The FSM SHALL have states IDLE, DIGIT1, READY, SEND, WAIT_RESP and LOCKED; all outputs SHALL be registered.
REQ-020 In IDLE, key_valid SHALL load key_code into pin[7:4], set digit_count=1 and move the FSM to DIGIT1.
REQ-021 In DIGIT1, key_valid SHALL load key_code into pin[3:0], set digit_count=2 and move the FSM to READY.
REQ-022 In READY, key_valid SHALL be ignored, so a third digit never overwrites the PIN.
REQ-023 key_enter SHALL be honoured only in READY; in IDLE and DIGIT1 it SHALL be ignored.
REQ-024 In IDLE, DIGIT1 and READY, key_clear SHALL zero pin, set digit_count=0 and move the FSM to IDLE; key_clear SHALL take priority over key_valid and key_enter in the same cycle.
REQ-025 key_enter sampled in READY at cycle N SHALL produce pin_valid=1 at cycle N+1 (SEND) for exactly one cycle, then the FSM SHALL move to WAIT_RESP.
REQ-026 input_password SHALL equal pin during SEND and WAIT_RESP, and SHALL be 8'h00 in every other state.
REQ-027 busy SHALL be 1 in SEND and WAIT_RESP only.
REQ-028 In SEND, WAIT_RESP and LOCKED, all key inputs (key_valid, key_enter, key_clear) SHALL be ignored.
REQ-029 WAIT_RESP SHALL run a response timer that starts at 0 on entry and increments by 1 each cycle, saturating at RESP_TIMEOUT.
REQ-030 In WAIT_RESP, gate_open=1 SHALL produce accepted=1 on the next cycle, clear pin and digit_count, and return the FSM to IDLE.
REQ-031 In WAIT_RESP, alarm_wrong_pin=1 SHALL produce rejected=1 on the next cycle, clear pin and digit_count, and return the FSM to IDLE.
REQ-032 If gate_open and alarm_wrong_pin are both 1 in the same cycle, accepted SHALL win and rejected SHALL NOT be asserted.
REQ-033 When the timer equals RESP_TIMEOUT-1 with no response, the module SHALL pulse timeout, clear pin and digit_count, and return to IDLE; a response arriving in that same cycle SHALL win over the timeout.
REQ-034 gate_open and alarm_wrong_pin SHALL be ignored outside WAIT_RESP.
REQ-035 Any unencoded state SHALL transition to IDLE on the next clock.

Reset
REQ-036 reset=0 SHALL asynchronously force state=IDLE, pin=0, digit_count=0, timer=0, reject counter=0 and lock timer=0.
REQ-037 During reset, input_password, pin_valid, busy, accepted, rejected, timeout and locked SHALL all be 0.
REQ-038 Asserting reset mid-transmission SHALL abort the transmission with no pin_valid or response pulse emitted.
REQ-039 Reset deassertion SHALL take effect at the first rising clk edge after deassertion.

Configuration
REQ-040 Macro PIN_ENTRY_LOCKOUT_EN SHALL compile the lockout feature in or out.
REQ-041 With PIN_ENTRY_LOCKOUT_EN defined, a 2-bit reject counter SHALL increment on each rejected, clear on accepted, and be left unchanged by timeout.
REQ-042 With PIN_ENTRY_LOCKOUT_EN defined, the third consecutive reject SHALL move the FSM to LOCKED instead of IDLE, with locked=1 for exactly LOCK_CYCLES cycles.
REQ-043 With PIN_ENTRY_LOCKOUT_EN defined, leaving LOCKED SHALL move the FSM to IDLE and clear the reject counter.
REQ-044 Without PIN_ENTRY_LOCKOUT_EN, the LOCKED state and reject counter SHALL be absent, the locked port SHALL remain present and tied to 0, and rejects SHALL always return the FSM to IDLE.

Verification
REQ-045 Keys 4, 9, then key_enter -> pin_valid=1 for one cycle with input_password=8'h49; gate_open 3 cycles later -> accepted pulse, IDLE, digit_count=0.
REQ-046 Key 4, key_clear, then keys 1, 2 and key_enter -> transmitted input_password=8'h12; a key_enter issued after only one digit -> no pin_valid.
REQ-047 Keys 4, 9, 7 and key_enter -> input_password=8'h49 (the third digit is ignored).
REQ-048 Send a PIN with no response, RESP_TIMEOUT=16 -> timeout pulse 16 cycles after the WAIT_RESP entry cycle; gate_open and alarm_wrong_pin both 1 in the same cycle -> accepted only.
REQ-049 With PIN_ENTRY_LOCKOUT_EN, three rejects -> locked=1 for 64 cycles with keys ignored, then a PIN is accepted normally; without the macro, locked stays 0.
REQ-050 reset=0 asserted in WAIT_RESP, between clock edges -> all outputs 0 immediately; after release, no stale accepted, rejected or timeout pulse.
